// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID fields, forwarding sources, ALU/EX outputs and STALL.
// The stage itself is the slave; the upstream/downstream environment is the master.
interface id_ex_if;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [31:0] id_imm;
  logic [4:0]  id_alu_select;
  logic        id_op1_pc;
  logic        id_op2_imm;
  logic [4:0]  id_rd_addr;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        flush;
  logic [4:0]  mem_rd_addr;
  logic        mem_reg_write;
  logic [31:0] mem_result;
  logic [4:0]  wb_rd_addr;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic [31:0] alu_data1;
  logic [31:0] alu_data2;
  logic [4:0]  alu_select;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic [31:0] ex_rs2_fwd;
  logic        stall;

  modport master (
    output id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
           id_imm, id_alu_select, id_op1_pc, id_op2_imm, id_rd_addr, id_reg_write,
           id_mem_read, flush, mem_rd_addr, mem_reg_write, mem_result,
           wb_rd_addr, wb_reg_write, wb_data,
    input  alu_data1, alu_data2, alu_select, ex_valid, ex_pc, ex_rd_addr,
           ex_reg_write, ex_mem_read, ex_rs2_fwd, stall
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
           id_imm, id_alu_select, id_op1_pc, id_op2_imm, id_rd_addr, id_reg_write,
           id_mem_read, flush, mem_rd_addr, mem_reg_write, mem_result,
           wb_rd_addr, wb_reg_write, wb_data,
    output alu_data1, alu_data2, alu_select, ex_valid, ex_pc, ex_rd_addr,
           ex_reg_write, ex_mem_read, ex_rs2_fwd, stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// RV32IM ID/EX stage: EX register bank, EX/MEM + MEM/WB forwarding, load-use bubbles.
// Define DIV_STALL_EN to hold DIV/DIVU/REM/REMU in EX for DIV_LATENCY cycles.
module id_ex_stage #(
  parameter int DIV_LATENCY = 4
) (
  input logic   i_clk,
  input logic   i_reset_n,
  id_ex_if.slave bus
);
  // Handshake: STALL is combinational; when high, IF/ID must present the same instruction next cycle.
  logic        r_valid;
  logic [31:0] r_pc;
  logic [4:0]  r_rs1_addr;
  logic [4:0]  r_rs2_addr;
  logic [31:0] r_rs1_data;
  logic [31:0] r_rs2_data;
  logic [31:0] r_imm;
  logic [4:0]  r_select;
  logic        r_op1_pc;
  logic        r_op2_imm;
  logic [4:0]  r_rd_addr;
  logic        r_reg_write;
  logic        r_mem_read;

  logic        w_div_busy;
  logic        w_load_use;
  logic        w_bubble;
  logic [31:0] w_fwd_rs1;
  logic [31:0] w_fwd_rs2;

`ifdef DIV_STALL_EN
  localparam int CNT_W = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;
  localparam logic [4:0] SEL_DIV  = 5'd14;
  localparam logic [4:0] SEL_DIVU = 5'd15;
  localparam logic [4:0] SEL_REM  = 5'd16;
  localparam logic [4:0] SEL_REMU = 5'd17;

  logic [CNT_W-1:0] r_div_cnt;

  function automatic logic is_div(input logic [4:0] sel);
    return (sel == SEL_DIV) || (sel == SEL_DIVU) || (sel == SEL_REM) || (sel == SEL_REMU);
  endfunction

  assign w_div_busy = (r_div_cnt != '0);

  // Counter holds the remaining extra cycles of the divide occupying EX.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n || bus.flush) begin
      r_div_cnt <= '0;
    end else if (w_div_busy) begin
      r_div_cnt <= r_div_cnt - CNT_W'(1);
    end else if (!w_load_use && bus.id_valid && is_div(bus.id_alu_select)) begin
      r_div_cnt <= CNT_W'(DIV_LATENCY - 1);
    end
  end
`else
  assign w_div_busy = 1'b0;
`endif

  assign w_load_use = r_valid && r_mem_read && (r_rd_addr != 5'd0) && bus.id_valid &&
                      ((r_rd_addr == bus.id_rs1_addr) || (r_rd_addr == bus.id_rs2_addr));
  assign w_bubble   = bus.flush || (!w_div_busy && w_load_use);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || w_bubble) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_rs1_addr  <= '0;
      r_rs2_addr  <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_select    <= '0;
      r_op1_pc    <= 1'b0;
      r_op2_imm   <= 1'b0;
      r_rd_addr   <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
    end else if (!w_div_busy) begin
      r_valid     <= bus.id_valid;
      r_pc        <= bus.id_pc;
      r_rs1_addr  <= bus.id_rs1_addr;
      r_rs2_addr  <= bus.id_rs2_addr;
      r_rs1_data  <= bus.id_rs1_data;
      r_rs2_data  <= bus.id_rs2_data;
      r_imm       <= bus.id_imm;
      r_select    <= bus.id_alu_select;
      r_op1_pc    <= bus.id_op1_pc;
      r_op2_imm   <= bus.id_op2_imm;
      r_rd_addr   <= bus.id_rd_addr;
      r_reg_write <= bus.id_reg_write;
      r_mem_read  <= bus.id_mem_read;
    end
  end

  // MEM beats WB; x0 is never forwarded. Re-evaluated every cycle, including while held.
  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] reg_data);
    if (rs != 5'd0 && bus.mem_reg_write && bus.mem_rd_addr == rs) return bus.mem_result;
    if (rs != 5'd0 && bus.wb_reg_write && bus.wb_rd_addr == rs)   return bus.wb_data;
    return reg_data;
  endfunction

  assign w_fwd_rs1 = fwd(r_rs1_addr, r_rs1_data);
  assign w_fwd_rs2 = fwd(r_rs2_addr, r_rs2_data);

  assign bus.alu_data1    = r_op1_pc  ? r_pc  : w_fwd_rs1;
  assign bus.alu_data2    = r_op2_imm ? r_imm : w_fwd_rs2;
  assign bus.alu_select   = r_select;
  assign bus.ex_valid     = r_valid;
  assign bus.ex_pc        = r_pc;
  assign bus.ex_rd_addr   = r_rd_addr;
  assign bus.ex_reg_write = r_reg_write;
  assign bus.ex_mem_read  = r_mem_read;
  assign bus.ex_rs2_fwd   = w_fwd_rs2;
  assign bus.stall        = !bus.flush && (w_div_busy || w_load_use);
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed test-plan steps then random traffic against a slot-level model.
module tb_id_ex_stage;
  localparam int DIV_LAT = 4;
  localparam logic [4:0] SEL_ADD = 5'd0;
  localparam logic [4:0] SEL_SUB = 5'd1;
  localparam logic [4:0] SEL_DIV = 5'd14;
  localparam logic [4:0] SEL_REM = 5'd16;
`ifdef DIV_STALL_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_if bus();
  id_ex_stage #(.DIV_LATENCY(DIV_LAT)) dut (.i_clk(clk), .i_reset_n(rst_n), .bus(bus));

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2;
    logic [31:0] d1, d2, imm;
    logic [4:0]  sel;
    logic        op1pc, op2imm;
    logic [4:0]  rd;
    logic        rw, mr;
  } slot_t;

  slot_t       ex;
  int          div_left = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic        last_stall = 1'b0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] d);
    if (rs != 0 && bus.mem_reg_write && bus.mem_rd_addr == rs) return bus.mem_result;
    if (rs != 0 && bus.wb_reg_write && bus.wb_rd_addr == rs)   return bus.wb_data;
    return d;
  endfunction

  function automatic bit is_div(input logic [4:0] s);
    return s >= 5'd14 && s <= 5'd17;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    e = exp_q.pop_front();
    n_tests++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] e);
    exp_q.push_back(e);
    chk(tag, obs);
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [31:0] d1, input logic [4:0] rs2, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [4:0] sel, input logic op1pc,
                        input logic op2imm, input logic [4:0] rd, input logic rw, input logic mr);
    bus.id_valid = v;        bus.id_pc = pc;
    bus.id_rs1_addr = rs1;   bus.id_rs1_data = d1;
    bus.id_rs2_addr = rs2;   bus.id_rs2_data = d2;
    bus.id_imm = imm;        bus.id_alu_select = sel;
    bus.id_op1_pc = op1pc;   bus.id_op2_imm = op2imm;
    bus.id_rd_addr = rd;     bus.id_reg_write = rw;
    bus.id_mem_read = mr;
  endtask

  task automatic set_idle();
    set_id(0, 0, 0, 0, 0, 0, 0, SEL_ADD, 0, 0, 0, 0, 0);
  endtask

  task automatic set_fwd(input logic [4:0] mrd, input logic mrw, input logic [31:0] mres,
                         input logic [4:0] wrd, input logic wrw, input logic [31:0] wdat);
    bus.mem_rd_addr = mrd; bus.mem_reg_write = mrw; bus.mem_result = mres;
    bus.wb_rd_addr = wrd;  bus.wb_reg_write = wrw;  bus.wb_data = wdat;
  endtask

  // One clock: check all outputs against the model, then advance the model at the edge.
  task automatic cycle();
    logic        lu;
    logic [31:0] f1, f2;
    logic        st;
    #1;
    lu = ex.valid && ex.mr && ex.rd != 0 && bus.id_valid &&
         (ex.rd == bus.id_rs1_addr || ex.rd == bus.id_rs2_addr);
    f1 = ref_fwd(ex.rs1, ex.d1);
    f2 = ref_fwd(ex.rs2, ex.d2);
    st = !bus.flush && (div_left > 0 || lu);
    exp_q.push_back(ex.op1pc ? ex.pc : f1);
    exp_q.push_back(ex.op2imm ? ex.imm : f2);
    exp_q.push_back(32'(ex.sel));
    exp_q.push_back(32'(ex.valid));
    exp_q.push_back(ex.pc);
    exp_q.push_back(32'(ex.rd));
    exp_q.push_back(32'(ex.rw));
    exp_q.push_back(32'(ex.mr));
    exp_q.push_back(f2);
    exp_q.push_back(32'(st));
    chk("alu_data1",    bus.alu_data1);
    chk("alu_data2",    bus.alu_data2);
    chk("alu_select",   32'(bus.alu_select));
    chk("ex_valid",     32'(bus.ex_valid));
    chk("ex_pc",        bus.ex_pc);
    chk("ex_rd_addr",   32'(bus.ex_rd_addr));
    chk("ex_reg_write", 32'(bus.ex_reg_write));
    chk("ex_mem_read",  32'(bus.ex_mem_read));
    chk("ex_rs2_fwd",   bus.ex_rs2_fwd);
    chk("stall",        32'(bus.stall));
    last_stall = st;
    @(posedge clk);
    if (!rst_n || bus.flush) begin
      ex = '{default: 0};
      div_left = 0;
    end else if (div_left > 0) begin
      div_left--;
    end else if (lu) begin
      ex = '{default: 0};
    end else begin
      ex.valid = bus.id_valid;   ex.pc = bus.id_pc;
      ex.rs1 = bus.id_rs1_addr;  ex.d1 = bus.id_rs1_data;
      ex.rs2 = bus.id_rs2_addr;  ex.d2 = bus.id_rs2_data;
      ex.imm = bus.id_imm;       ex.sel = bus.id_alu_select;
      ex.op1pc = bus.id_op1_pc;  ex.op2imm = bus.id_op2_imm;
      ex.rd = bus.id_rd_addr;    ex.rw = bus.id_reg_write;
      ex.mr = bus.id_mem_read;
      div_left = (DIV_EN && bus.id_valid && is_div(bus.id_alu_select)) ? DIV_LAT - 1 : 0;
    end
    @(negedge clk);
  endtask

  initial begin
    ex = '{default: 0};
    set_idle();
    set_fwd(0, 0, 0, 0, 0, 0);
    bus.flush = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // Reset state
    cycle();
    cycle();
    chk_val("reset_alu_data1", bus.alu_data1, 32'd0);
    chk_val("reset_stall", 32'(bus.stall), 32'd0);
    rst_n = 1'b1;

    // Plain ADD x1=5, x2=10
    set_id(1, 32'h100, 1, 5, 2, 10, 0, SEL_ADD, 0, 0, 7, 1, 0);
    cycle();
    set_idle();
    chk_val("add_data1", bus.alu_data1, 32'd5);
    chk_val("add_data2", bus.alu_data2, 32'd10);
    chk_val("add_valid", 32'(bus.ex_valid), 32'd1);
    cycle();

    // MEM beats WB; x0 never forwarded
    set_id(1, 32'h104, 3, 7, 0, 32'h1234, 0, SEL_SUB, 0, 0, 9, 1, 0);
    cycle();
    set_idle();
    set_fwd(3, 1, 15, 3, 1, 99);
    #1 chk_val("fwd_mem_over_wb", bus.alu_data1, 32'd15);
    cycle();
    set_id(1, 32'h108, 0, 32'h1234, 0, 0, 0, SEL_ADD, 0, 0, 9, 1, 0);
    set_fwd(0, 1, 15, 0, 1, 99);
    cycle();
    set_idle();
    #1 chk_val("fwd_x0_none", bus.alu_data1, 32'h1234);
    cycle();
    set_fwd(0, 0, 0, 0, 0, 0);

    // Load-use: load x4 then consumer of x4 in rs2
    set_id(1, 32'h10c, 5, 0, 0, 0, 4, SEL_ADD, 0, 1, 4, 1, 1);
    cycle();
    set_id(1, 32'h110, 6, 1, 4, 0, 0, SEL_ADD, 0, 0, 8, 1, 0);
    #1 chk_val("lu_stall", 32'(bus.stall), 32'd1);
    cycle();
    set_fwd(4, 1, 32'haaa, 0, 0, 0);
    #1 chk_val("lu_bubble", 32'(bus.ex_valid), 32'd0);
    cycle();
    set_idle();
    set_fwd(0, 0, 0, 4, 1, 32'hbeef);
    #1 chk_val("lu_wb_fwd", bus.alu_data2, 32'hbeef);
    cycle();
    set_fwd(0, 0, 0, 0, 0, 0);

    // DIV 32/2 then a follower held behind it
    set_id(1, 32'h200, 1, 32, 2, 2, 0, SEL_DIV, 0, 0, 10, 1, 0);
    cycle();
    set_id(1, 32'h204, 1, 1, 2, 1, 0, SEL_ADD, 0, 0, 11, 1, 0);
    repeat (DIV_LAT + 1) begin
      chk_val("div_seen", 32'(bus.alu_select == SEL_DIV || bus.ex_pc == 32'h204), 32'd1);
      cycle();
    end

    // FLUSH in the 2nd cycle of a divide
    set_id(1, 32'h208, 1, 32, 2, 2, 0, SEL_DIV, 0, 0, 10, 1, 0);
    cycle();
    set_id(1, 32'h20c, 1, 1, 2, 1, 0, SEL_ADD, 0, 0, 11, 1, 0);
    cycle();
    bus.flush = 1'b1;
    #1 chk_val("flush_stall", 32'(bus.stall), 32'd0);
    cycle();
    bus.flush = 1'b0;
    chk_val("flush_killed", 32'(bus.ex_valid), 32'd0);
    set_idle();
    cycle();

    // Reset mid-divide, then REM 31/2
    set_id(1, 32'h300, 1, 32, 2, 2, 0, SEL_DIV, 0, 0, 10, 1, 0);
    cycle();
    set_idle();
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk_val("rst_mid_valid", 32'(bus.ex_valid), 32'd0);
    chk_val("rst_mid_data1", bus.alu_data1, 32'd0);
    set_id(1, 32'h304, 1, 31, 2, 2, 0, SEL_REM, 0, 0, 12, 1, 0);
    cycle();
    set_idle();
    repeat (DIV_LAT) cycle();

    // Random traffic; IF/ID holds its instruction while STALL is high
    for (int n = 0; n < 600; n++) begin
      if (!last_stall || bus.flush) begin
        set_id($urandom_range(0, 3) != 0, $urandom, 5'($urandom_range(0, 7)), $urandom,
               5'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 17)),
               $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
               5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
      end
      set_fwd(5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, $urandom,
              5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, $urandom);
      bus.flush = ($urandom_range(0, 15) == 0);
      rst_n = ($urandom_range(0, 63) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
